// File: rtl/baccarat_pkg.sv
// Shared types and helpers for the baccarat hand dealer: FSM states,
// rank constants and the rank-to-point mapping.
package baccarat_pkg;

    typedef enum logic [3:0] {
        P1      = 4'd0,
        D1      = 4'd1,
        P2      = 4'd2,
        D2      = 4'd3,
        CHK_NAT = 4'd4,
        P_DEC   = 4'd5,
        P3      = 4'd6,
        D_DEC   = 4'd7,
        D3      = 4'd8,
        RESULT  = 4'd9
    } state_t;

    localparam logic [3:0] RANK_EMPTY = 4'd0;
    localparam logic [3:0] RANK_ACE   = 4'd1;
    localparam logic [3:0] RANK_KING  = 4'd13;

    // Tens, faces and anything out of range count zero; an empty slot is rank 0.
    function automatic logic [3:0] card_value(input logic [3:0] rank);
        if (rank >= 4'd10) begin
            return 4'd0;
        end else begin
            return rank;
        end
    endfunction

endpackage

// File: rtl/hand_score.sv
// Baccarat score of a three-slot hand: sum of card values modulo 10.
module hand_score
    import baccarat_pkg::*;
(
    input  logic [3:0] card_a,
    input  logic [3:0] card_b,
    input  logic [3:0] card_c,
    output logic [3:0] score
);

    logic [4:0] sum_s;

    // Sum is at most 27, so two conditional subtractions replace a modulo.
    always_comb begin
        sum_s = {1'b0, card_value(card_a)} + {1'b0, card_value(card_b)}
              + {1'b0, card_value(card_c)};
        if (sum_s >= 5'd20) begin
            score = 4'(sum_s - 5'd20);
        end else if (sum_s >= 5'd10) begin
            score = 4'(sum_s - 5'd10);
        end else begin
            score = sum_s[3:0];
        end
    end

endmodule

// File: rtl/baccarat_hand.sv
// Deals one punto banco hand from strobed cards and reports the result.
// Optional rank checking is enabled by defining BACCARAT_CARD_CHECK_EN.
module baccarat_hand
    import baccarat_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] new_card,
    input  logic       step,
    output logic [3:0] pcard1,
    output logic [3:0] pcard2,
    output logic [3:0] pcard3,
    output logic [3:0] dcard1,
    output logic [3:0] dcard2,
    output logic [3:0] dcard3,
    output logic [3:0] pscore,
    output logic [3:0] dscore,
    output logic       player_wins,
    output logic       dealer_wins,
    output logic       done,
    output logic       bad_card
);

    state_t     state_r;
    state_t     next_state_s;
    logic       player_stood_r;
    logic       next_stood_s;
    logic       load_s;
    logic       clear_s;
    logic       reject_s;
    logic       card_ok_s;
    logic       banker_draws_s;
    logic [3:0] third_val_s;

`ifdef BACCARAT_CARD_CHECK_EN
    assign card_ok_s = (new_card >= RANK_ACE) && (new_card <= RANK_KING);
`else
    assign card_ok_s = 1'b1;
`endif

    hand_score u_player_score (
        .card_a (pcard1),
        .card_b (pcard2),
        .card_c (pcard3),
        .score  (pscore)
    );

    hand_score u_dealer_score (
        .card_a (dcard1),
        .card_b (dcard2),
        .card_c (dcard3),
        .score  (dscore)
    );

    // Banker tableau when the player has taken a third card.
    always_comb begin
        third_val_s = card_value(pcard3);
        if (dscore <= 4'd2) begin
            banker_draws_s = 1'b1;
        end else if (dscore == 4'd3) begin
            banker_draws_s = (third_val_s != 4'd8);
        end else if (dscore == 4'd4) begin
            banker_draws_s = (third_val_s >= 4'd2) && (third_val_s <= 4'd7);
        end else if (dscore == 4'd5) begin
            banker_draws_s = (third_val_s >= 4'd4) && (third_val_s <= 4'd7);
        end else if (dscore == 4'd6) begin
            banker_draws_s = (third_val_s >= 4'd6) && (third_val_s <= 4'd7);
        end else begin
            banker_draws_s = 1'b0;
        end
    end

    // Next-state and slot-control decode.
    always_comb begin
        next_state_s = state_r;
        next_stood_s = player_stood_r;
        load_s       = 1'b0;
        clear_s      = 1'b0;
        reject_s     = 1'b0;
        case (state_r)
            P1, D1, P2, D2, P3, D3: begin
                if (step && card_ok_s) begin
                    load_s = 1'b1;
                    case (state_r)
                        P1:      next_state_s = D1;
                        D1:      next_state_s = P2;
                        P2:      next_state_s = D2;
                        D2:      next_state_s = CHK_NAT;
                        P3:      next_state_s = D_DEC;
                        D3:      next_state_s = RESULT;
                        default: next_state_s = P1;
                    endcase
                end else if (step) begin
                    reject_s = 1'b1;
                end else begin
                    next_state_s = state_r;
                end
            end
            CHK_NAT: begin
                if ((pscore >= 4'd8) || (dscore >= 4'd8)) begin
                    next_state_s = RESULT;
                end else begin
                    next_state_s = P_DEC;
                end
            end
            P_DEC: begin
                if (pscore <= 4'd5) begin
                    next_state_s = P3;
                    next_stood_s = 1'b0;
                end else begin
                    next_state_s = D_DEC;
                    next_stood_s = 1'b1;
                end
            end
            D_DEC: begin
                if (player_stood_r) begin
                    next_state_s = (dscore <= 4'd5) ? D3 : RESULT;
                end else begin
                    next_state_s = banker_draws_s ? D3 : RESULT;
                end
            end
            RESULT: begin
                if (step) begin
                    clear_s      = 1'b1;
                    next_state_s = P1;
                end else begin
                    next_state_s = RESULT;
                end
            end
            default: next_state_s = P1;
        endcase
    end

    // State, stand flag, card slots and reject pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= P1;
            player_stood_r <= 1'b0;
            pcard1         <= RANK_EMPTY;
            pcard2         <= RANK_EMPTY;
            pcard3         <= RANK_EMPTY;
            dcard1         <= RANK_EMPTY;
            dcard2         <= RANK_EMPTY;
            dcard3         <= RANK_EMPTY;
            bad_card       <= 1'b0;
        end else begin
            state_r        <= next_state_s;
            player_stood_r <= next_stood_s;
            bad_card       <= reject_s;
            if (clear_s) begin
                pcard1 <= RANK_EMPTY;
                pcard2 <= RANK_EMPTY;
                pcard3 <= RANK_EMPTY;
                dcard1 <= RANK_EMPTY;
                dcard2 <= RANK_EMPTY;
                dcard3 <= RANK_EMPTY;
            end else if (load_s) begin
                case (state_r)
                    P1:      pcard1 <= new_card;
                    D1:      dcard1 <= new_card;
                    P2:      pcard2 <= new_card;
                    D2:      dcard2 <= new_card;
                    P3:      pcard3 <= new_card;
                    D3:      dcard3 <= new_card;
                    default: pcard1 <= pcard1;
                endcase
            end
        end
    end

    assign done        = (state_r == RESULT);
    assign player_wins = done && (pscore >= dscore);
    assign dealer_wins = done && (dscore >= pscore);

endmodule

// File: tb/tb_baccarat_hand.sv
// Self-checking bench for baccarat_hand: directed hands plus random hands
// compared against a rule-level reference model of punto banco.
module tb_baccarat_hand;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       step = 1'b0;
    logic [3:0] new_card = 4'd0;
    logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
    logic [3:0] pscore, dscore;
    logic       player_wins, dealer_wins, done, bad_card;

    int tests = 0;
    int fails = 0;
    int deck [6];
    int ep [3];
    int ed [3];
    int eps, eds, ncards;
    bit pdrew;

    baccarat_hand dut (
        .clock       (clock),
        .reset       (reset),
        .new_card    (new_card),
        .step        (step),
        .pcard1      (pcard1),
        .pcard2      (pcard2),
        .pcard3      (pcard3),
        .dcard1      (dcard1),
        .dcard2      (dcard2),
        .dcard3      (dcard3),
        .pscore      (pscore),
        .dscore      (dscore),
        .player_wins (player_wins),
        .dealer_wins (dealer_wins),
        .done        (done),
        .bad_card    (bad_card)
    );

    always #5 clock = ~clock;

    function automatic int val(int r);
        return (r >= 10) ? 0 : r;
    endfunction

    // Plays the hand in deck[] by the printed baccarat rules.
    task automatic model();
        int v;
        bit draw;
        ep = '{deck[0], deck[2], 0};
        ed = '{deck[1], deck[3], 0};
        eps = (val(deck[0]) + val(deck[2])) % 10;
        eds = (val(deck[1]) + val(deck[3])) % 10;
        ncards = 4;
        pdrew = 1'b0;
        if (eps >= 8 || eds >= 8) return;
        if (eps <= 5) begin
            pdrew = 1'b1;
            ep[2] = deck[4];
            ncards = 5;
            v = val(deck[4]);
            eps = (eps + v) % 10;
            draw = (eds <= 2) || (eds == 3 && v != 8) || (eds == 4 && v >= 2 && v <= 7)
                || (eds == 5 && v >= 4 && v <= 7) || (eds == 6 && v >= 6 && v <= 7);
            if (draw) begin
                ed[2] = deck[5];
                ncards = 6;
                eds = (eds + val(deck[5])) % 10;
            end
        end else if (eds <= 5) begin
            ed[2] = deck[4];
            ncards = 5;
            eds = (eds + val(deck[4])) % 10;
        end
    endtask

    task automatic chk(string tag, int obs, int exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic strobe(int c);
        new_card = 4'(c);
        step = 1'b1;
        tick();
        step = 1'b0;
        new_card = 4'($urandom_range(0, 15));
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_p1"}, pcard1, 0);
        chk({tag, "_p2"}, pcard2, 0);
        chk({tag, "_d1"}, dcard1, 0);
        chk({tag, "_ps"}, pscore, 0);
        chk({tag, "_ds"}, dscore, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pw"}, player_wins, 0);
        chk({tag, "_dw"}, dealer_wins, 0);
        chk({tag, "_bad"}, bad_card, 0);
    endtask

    // Deals deck[] from P1, checks the result, then replays back to P1.
    task automatic play_hand();
        model();
        strobe(deck[0]);
        chk("latency_pcard1", pcard1, deck[0]);
        for (int i = 1; i < 4; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            strobe(deck[i]);
        end
        new_card = 4'($urandom_range(1, 13));
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        tick();
        if (ncards > 4) begin
            chk("done_before_third", done, 0);
            strobe(deck[4]);
            if (pdrew) begin
                new_card = 4'($urandom_range(1, 13));
                step = 1'b1;
                tick();
                step = 1'b0;
            end
            tick();
            tick();
            if (ncards > 5) begin
                strobe(deck[5]);
                tick();
            end
        end
        chk("pcard1", pcard1, ep[0]);
        chk("pcard2", pcard2, ep[1]);
        chk("pcard3", pcard3, ep[2]);
        chk("dcard1", dcard1, ed[0]);
        chk("dcard2", dcard2, ed[1]);
        chk("dcard3", dcard3, ed[2]);
        chk("pscore", pscore, eps);
        chk("dscore", dscore, eds);
        chk("done", done, 1);
        chk("player_wins", player_wins, (eps >= eds) ? 1 : 0);
        chk("dealer_wins", dealer_wins, (eds >= eps) ? 1 : 0);
        strobe($urandom_range(1, 13));
        chk("replay_done", done, 0);
        chk("replay_pcard1", pcard1, 0);
        chk("replay_pcard3", pcard3, 0);
        chk("replay_dcard3", dcard3, 0);
        chk("replay_pscore", pscore, 0);
    endtask

    initial begin
        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b0;

        deck = '{4, 5, 10, 3, 0, 0};
        play_hand();
        chk("natural_ps", eps, 4);
        chk("natural_ds", eds, 8);

        deck = '{1, 2, 3, 4, 6, 1};
        play_hand();
        chk("banker_ds", eds, 7);

        deck = '{7, 7, 13, 12, 0, 0};
        play_hand();
        chk("tie_ps", eps, 7);

        // Out-of-range rank strobed in D1.
        strobe(5);
        strobe(0);
        chk("badcard_dcard1", dcard1, 0);
`ifdef BACCARAT_CARD_CHECK_EN
        chk("badcard_pulse", bad_card, 1);
        tick();
        chk("badcard_clear", bad_card, 0);
        strobe(6);
        chk("badcard_reload", dcard1, 6);
`else
        chk("badcard_tied", bad_card, 0);
`endif
        strobe(2);
        chk("badcard_advance", pcard2, 2);

        // Reset mid-hand wins over a simultaneous strobe.
        reset = 1'b1;
        new_card = 4'd5;
        step = 1'b1;
        tick();
        reset = 1'b0;
        step = 1'b0;
        chk_all_zero("midreset");
        strobe(9);
        chk("midreset_p1", pcard1, 9);
        chk("midreset_d1", dcard1, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        for (int h = 0; h < 60; h++) begin
            for (int k = 0; k < 6; k++) deck[k] = $urandom_range(1, 13);
            play_hand();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
